exmem_skid_reg: RTL and testbench
=================================

EXMEM_SKID_REG -- requirements
Module: exmem_skid_reg

Interface
REQ-001 SHALL provide parameter ADDR_W, default 8, meaning branch-target width.
REQ-002 SHALL provide parameter DATA_W, default 32, meaning ALU-result and store-data width.
REQ-003 SHALL provide parameter REG_W, default 5, meaning destination-register index width.
REQ-004 SHALL provide parameter CNT_W, default 16, meaning stall-counter width.
REQ-005 SHALL have port clk_EMR  in  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n_EMR  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush_EMR  in  1  synchronous kill of all held entries.
REQ-008 SHALL have port in_valid  in  1  upstream (EX) entry present.
REQ-009 SHALL have port in_ready  out  1  block accepts an entry this cycle; registered.
REQ-010 SHALL have port in payload: resAdd_IN ADDR_W, zf_IN 1, resALU_IN DATA_W, regData2_IN DATA_W, dest_IN REG_W, M_IN 3 ({branch,memRead,memWrite}), WB_IN 2.
REQ-011 SHALL have port out_valid  out  1  head entry present.
REQ-012 SHALL have port out_ready  in  1  downstream (MEM) consumes the head.
REQ-013 SHALL have port out payload: resAdd, zf, resALU, regData2, dest, WB, branch, memRead, memWrite; widths as inputs.
REQ-014 SHALL have port pcSrc  out  1  out_valid AND branch AND zf, combinational from head registers.
REQ-015 SHALL have port stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 SHALL hold up to two entries: MAIN (drives outputs) and SKID (overflow).
REQ-017 SHALL run FSM EMPTY/ONE/TWO; out_valid=1 in ONE and TWO.
REQ-018 SHALL transfer on an input when in_valid and in_ready are both 1, and on an output when out_valid and out_ready are both 1.
REQ-019 EMPTY: on input, load MAIN and go to ONE.
REQ-020 ONE: input only -> load SKID, TWO; output only -> EMPTY; both -> load MAIN, stay ONE.
REQ-021 TWO: output -> move SKID to MAIN, go to ONE; in_ready=0, so no input occurs.
REQ-022 in_ready SHALL be 1 exactly when the state is not TWO; it is a flop and never depends on out_ready.
REQ-023 Latency SHALL be one cycle: an entry accepted at edge N is on the outputs after edge N with out_valid=1.
REQ-024 Payload SHALL be held unchanged while out_valid=1 and out_ready=0.
REQ-025 flush_EMR SHALL take priority over any input or output transfer in the same cycle: next state EMPTY, branch/memRead/memWrite/WB zeroed (bubble), data fields don't-care.
REQ-026 When out_valid=0, branch, memRead, memWrite and WB SHALL read 0.
REQ-027 stall_cnt SHALL increment by 1 per stall cycle, saturate at all-ones, and be unaffected by flush.
REQ-028 Widths SHALL pass through unchanged, with no truncation or extension.

Reset
REQ-029 While rst_n_EMR=0 the block SHALL be in state EMPTY with in_ready=0, out_valid=0, every payload output 0, pcSrc=0 and stall_cnt=0.
REQ-030 in_ready SHALL rise to 1 on the first clock edge after reset deasserts.
REQ-031 Reset asserted mid-operation SHALL discard both entries immediately, without waiting for a clock edge.

Structure
REQ-032 Package exmem_pkg SHALL hold the FSM state enum, M-field bit indices (M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0) and the WB width constant.
REQ-033 A sub-module pipe_slot (an enable-loaded payload register with async clear) SHALL be instantiated twice, once for MAIN and once for SKID.

Verification
REQ-034 Reset deassert, in_valid=1, resALU_IN=0x0000_00A5, M_IN=3'b010, out_ready=1 -> next cycle out_valid=1, resALU=0xA5, memRead=1.
REQ-035 out_ready=0, push two entries (0x11, 0x22) -> state TWO, in_ready=0, resALU stays 0x11; out_ready=1 -> 0x11 then 0x22 appear on consecutive cycles.
REQ-036 M_IN=3'b100, zf_IN=1, resAdd_IN=0x3C -> pcSrc=1 and resAdd=0x3C for one cycle; zf_IN=0 -> pcSrc=0.
REQ-037 State TWO with flush_EMR=1 and in_valid=1 on the same edge -> EMPTY, out_valid=0, memWrite=0, in_ready=1 next cycle.
REQ-038 Hold out_ready=0 with out_valid=1 for 70000 cycles (CNT_W=16) -> stall_cnt saturates at 0xFFFF.
REQ-039 Assert rst_n_EMR low mid-cycle while in TWO -> out_valid and stall_cnt go to 0 before the next edge.

Source files
------------

// File: rtl/exmem_pkg.sv
// exmem_pkg: shared FSM states, M-field bit positions and WB width for the EX/MEM skid register
package exmem_pkg;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;
  localparam int WB_W       = 2;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: enable-loaded payload register with async active-low clear (clk_i, rst_ni, en_i, d_i -> q_o)
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) q_o <= '0;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/exmem_skid_reg.sv
// exmem_skid_reg: two-entry EX/MEM skid register (valid/ready in, valid/ready out, payload, pcSrc, stall counter)
module exmem_skid_reg
  import exmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_EMR,
  input  logic              rst_n_EMR,
  input  logic              flush_EMR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] resAdd_IN,
  input  logic              zf_IN,
  input  logic [DATA_W-1:0] resALU_IN,
  input  logic [DATA_W-1:0] regData2_IN,
  input  logic [REG_W-1:0]  dest_IN,
  input  logic [2:0]        M_IN,
  input  logic [WB_W-1:0]   WB_IN,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] resAdd,
  output logic              zf,
  output logic [DATA_W-1:0] resALU,
  output logic [DATA_W-1:0] regData2,
  output logic [REG_W-1:0]  dest,
  output logic [WB_W-1:0]   WB,
  output logic              branch,
  output logic              memRead,
  output logic              memWrite,
  output logic              pcSrc,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int PW = ADDR_W + 1 + 2 * DATA_W + REG_W + 3 + WB_W;
  state_e state_q, state_d;
  logic in_ready_q;
  logic [CNT_W-1:0] stall_q;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;
  logic in_fire, out_fire, main_en, skid_en;
  logic [2:0] m_h;
  logic [WB_W-1:0] wb_h;
  assign in_pl    = {resAdd_IN, zf_IN, resALU_IN, regData2_IN, dest_IN, M_IN, WB_IN};
  assign out_valid = state_q != S_EMPTY;
  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid && out_ready;
  always_comb begin
    state_d = flush_EMR ? S_EMPTY :
              state_q == S_EMPTY ? (in_fire ? S_ONE : S_EMPTY) :
              state_q == S_ONE ? ((in_fire && !out_fire) ? S_TWO : (!in_fire && out_fire) ? S_EMPTY : S_ONE) :
              (out_fire ? S_ONE : S_TWO);
    // MAIN refills from SKID when draining TWO, otherwise straight from the input
    main_en = !flush_EMR && (state_q == S_TWO ? out_fire : in_fire && (state_q == S_EMPTY || out_fire));
    skid_en = !flush_EMR && state_q == S_ONE && in_fire && !out_fire;
    main_d  = state_q == S_TWO ? skid_q : in_pl;
  end
  always_ff @(posedge clk_EMR or negedge rst_n_EMR)
    if (!rst_n_EMR) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d != S_TWO;
      if (out_valid && !out_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  pipe_slot #(.W(PW)) u_main (.clk_i(clk_EMR), .rst_ni(rst_n_EMR), .en_i(main_en), .d_i(main_d), .q_o(main_q));
  pipe_slot #(.W(PW)) u_skid (.clk_i(clk_EMR), .rst_ni(rst_n_EMR), .en_i(skid_en), .d_i(in_pl), .q_o(skid_q));
  assign {resAdd, zf, resALU, regData2, dest, m_h, wb_h} = main_q;
  // control fields read as a bubble whenever the head is empty (including after flush)
  assign branch    = out_valid && m_h[M_BRANCH];
  assign memRead   = out_valid && m_h[M_MEMREAD];
  assign memWrite  = out_valid && m_h[M_MEMWRITE];
  assign WB        = wb_h & {WB_W{out_valid}};
  assign pcSrc     = branch && zf;
  assign in_ready  = in_ready_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_exmem_skid_reg.sv
// tb_exmem_skid_reg: randomized and directed checks of exmem_skid_reg against a queue-based model
module tb_exmem_skid_reg;
  typedef struct packed {
    logic [7:0]  add;
    logic        zf;
    logic [31:0] alu;
    logic [31:0] d2;
    logic [4:0]  dest;
    logic [2:0]  m;
    logic [1:0]  wb;
  } entry_t;
  logic clk_EMR = 0, rst_n_EMR = 0, flush_EMR = 0, in_valid = 0, out_ready = 0;
  logic [7:0] resAdd_IN = 0;
  logic zf_IN = 0;
  logic [31:0] resALU_IN = 0, regData2_IN = 0;
  logic [4:0] dest_IN = 0;
  logic [2:0] M_IN = 0;
  logic [1:0] WB_IN = 0;
  logic in_ready, out_valid, zf, branch, memRead, memWrite, pcSrc;
  logic [7:0] resAdd;
  logic [31:0] resALU, regData2;
  logic [4:0] dest;
  logic [1:0] WB;
  logic [15:0] stall_cnt;
  int checks = 0, errors = 0;
  entry_t q[$];
  bit m_rdy = 0;
  int unsigned m_stall = 0;
  exmem_skid_reg dut (
    .clk_EMR(clk_EMR), .rst_n_EMR(rst_n_EMR), .flush_EMR(flush_EMR), .in_valid(in_valid), .in_ready(in_ready),
    .resAdd_IN(resAdd_IN), .zf_IN(zf_IN), .resALU_IN(resALU_IN), .regData2_IN(regData2_IN), .dest_IN(dest_IN),
    .M_IN(M_IN), .WB_IN(WB_IN), .out_valid(out_valid), .out_ready(out_ready), .resAdd(resAdd), .zf(zf),
    .resALU(resALU), .regData2(regData2), .dest(dest), .WB(WB), .branch(branch), .memRead(memRead),
    .memWrite(memWrite), .pcSrc(pcSrc), .stall_cnt(stall_cnt)
  );
  always #5 clk_EMR = ~clk_EMR;
  function automatic entry_t rnd_e();
    entry_t e;
    e.add = 8'($urandom); e.zf = 1'($urandom); e.alu = $urandom; e.d2 = $urandom;
    e.dest = 5'($urandom); e.m = 3'($urandom); e.wb = 2'($urandom);
    return e;
  endfunction
  function automatic entry_t mk(logic [31:0] alu, logic [2:0] m, logic z, logic [7:0] add);
    entry_t e = rnd_e();
    e.alu = alu; e.m = m; e.zf = z; e.add = add;
    return e;
  endfunction
  task automatic drive(bit v, entry_t e);
    in_valid = v; resAdd_IN = e.add; zf_IN = e.zf; resALU_IN = e.alu; regData2_IN = e.d2;
    dest_IN = e.dest; M_IN = e.m; WB_IN = e.wb;
  endtask
  task automatic model_reset();
    q.delete(); m_rdy = 0; m_stall = 0;
  endtask
  // advance one clock; model follows the queue semantics of a two-deep buffer
  task automatic tick();
    entry_t e = {resAdd_IN, zf_IN, resALU_IN, regData2_IN, dest_IN, M_IN, WB_IN};
    bit fi = in_valid && m_rdy;
    bit fo = q.size() > 0 && out_ready;
    bit st = q.size() > 0 && !out_ready;
    bit fl = flush_EMR;
    @(posedge clk_EMR);
    if (fl) q.delete();
    else begin
      if (fo) void'(q.pop_front());
      if (fi) q.push_back(e);
    end
    if (st && m_stall < 65535) m_stall++;
    m_rdy = q.size() < 2;
    #1;
  endtask
  task automatic test_reset();
    drive(1, rnd_e()); out_ready = 1; rst_n_EMR = 0; model_reset();
    repeat (3) @(posedge clk_EMR);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({resAdd, zf, resALU, regData2, dest, WB, branch, memRead, memWrite} !== '0) begin errors++; $display("FAIL reset_payload got nonzero"); end
    checks++; if (pcSrc !== 1'b0 || stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_pcsrc_stall got %b %h want 0 0", pcSrc, stall_cnt); end
    drive(0, rnd_e()); #2 rst_n_EMR = 1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
  endtask
  task automatic test_first();
    drive(1, mk(32'hA5, 3'b010, 0, 8'h00)); out_ready = 1;
    tick();
    drive(0, rnd_e());
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", out_valid); end
    checks++; if (resALU !== 32'hA5) begin errors++; $display("FAIL first_alu got %h want a5", resALU); end
    checks++; if (memRead !== 1'b1 || memWrite !== 1'b0 || branch !== 1'b0) begin errors++; $display("FAIL first_m got %b%b%b want 010", branch, memRead, memWrite); end
    tick();
    checks++; if (out_valid !== 1'b0 || memRead !== 1'b0) begin errors++; $display("FAIL first_drain got %b %b want 0 0", out_valid, memRead); end
  endtask
  task automatic test_skid();
    out_ready = 0;
    drive(1, mk(32'h11, 3'b000, 0, 8'h01)); tick();
    drive(1, mk(32'h22, 3'b000, 0, 8'h02)); tick();
    drive(0, rnd_e());
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready got %b want 0", in_ready); end
    checks++; if (resALU !== 32'h11 || out_valid !== 1'b1) begin errors++; $display("FAIL skid_head got %h %b want 11 1", resALU, out_valid); end
    tick();
    checks++; if (resALU !== 32'h11) begin errors++; $display("FAIL skid_hold got %h want 11", resALU); end
    out_ready = 1; tick();
    checks++; if (resALU !== 32'h22 || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL skid_second got %h %b %b want 22 1 1", resALU, out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty got %b want 0", out_valid); end
  endtask
  task automatic test_branch();
    out_ready = 1;
    drive(1, mk(32'h5, 3'b100, 1, 8'h3C)); tick(); drive(0, rnd_e());
    checks++; if (pcSrc !== 1'b1 || resAdd !== 8'h3C) begin errors++; $display("FAIL branch_taken got %b %h want 1 3c", pcSrc, resAdd); end
    tick();
    checks++; if (pcSrc !== 1'b0) begin errors++; $display("FAIL branch_oneshot got %b want 0", pcSrc); end
    drive(1, mk(32'h6, 3'b100, 0, 8'h3C)); tick(); drive(0, rnd_e());
    checks++; if (pcSrc !== 1'b0 || branch !== 1'b1) begin errors++; $display("FAIL branch_nottaken got %b %b want 0 1", pcSrc, branch); end
    tick();
  endtask
  task automatic test_flush();
    out_ready = 0;
    drive(1, mk(32'h31, 3'b001, 0, 0)); tick();
    drive(1, mk(32'h32, 3'b001, 0, 0)); tick();
    drive(1, mk(32'h33, 3'b001, 0, 0)); flush_EMR = 1; tick();
    flush_EMR = 0; drive(0, rnd_e());
    checks++; if (out_valid !== 1'b0 || memWrite !== 1'b0 || WB !== 2'b00) begin errors++; $display("FAIL flush_bubble got %b %b %b want 0 0 0", out_valid, memWrite, WB); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", in_ready); end
    checks++; if (stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL flush_stall got %h want %h", stall_cnt, m_stall); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, rnd_e());
      out_ready = $urandom_range(0, 2) != 0;
      flush_EMR = $urandom_range(0, 15) == 0;
      tick();
      flush_EMR = 0;
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid i=%0d got %b want %b", i, out_valid, q.size() > 0); end
      checks++; if (in_ready !== m_rdy) begin errors++; $display("FAIL rnd_ready i=%0d got %b want %b", i, in_ready, m_rdy); end
      checks++; if (stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall i=%0d got %h want %h", i, stall_cnt, m_stall); end
      if (q.size() > 0) begin
        checks++;
        if ({resAdd, zf, resALU, regData2, dest, branch, memRead, memWrite, WB} !== q[0]) begin
          errors++; $display("FAIL rnd_head i=%0d got %h want %h", i, {resAdd, zf, resALU, regData2, dest, branch, memRead, memWrite, WB}, q[0]);
        end
        checks++; if (pcSrc !== (q[0].m[2] && q[0].zf)) begin errors++; $display("FAIL rnd_pcsrc i=%0d got %b", i, pcSrc); end
      end else begin
        checks++; if ({branch, memRead, memWrite, WB, pcSrc} !== 6'b0) begin errors++; $display("FAIL rnd_bubble i=%0d got %b want 0", i, {branch, memRead, memWrite, WB, pcSrc}); end
      end
    end
  endtask
  task automatic test_stall_sat();
    out_ready = 1; drive(0, rnd_e()); tick(); tick();
    out_ready = 0; drive(1, rnd_e()); tick(); drive(0, rnd_e());
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (i % 4096 == 0) begin
        checks++; if (stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL stall_track i=%0d got %h want %h", i, stall_cnt, m_stall); end
      end
    end
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat got %h want ffff", stall_cnt); end
  endtask
  task automatic test_async_reset();
    out_ready = 0;
    drive(1, rnd_e()); tick();
    drive(0, rnd_e());
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL areset_two got %b %b want 0 1", in_ready, out_valid); end
    #2 rst_n_EMR = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'h0) begin errors++; $display("FAIL areset_clear got %b %h want 0 0", out_valid, stall_cnt); end
    checks++; if (in_ready !== 1'b0 || resALU !== 32'h0) begin errors++; $display("FAIL areset_ready got %b %h want 0 0", in_ready, resALU); end
    model_reset();
    @(posedge clk_EMR); #2 rst_n_EMR = 1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL areset_release got %b %b want 1 0", in_ready, out_valid); end
  endtask
  initial begin
    test_reset();
    test_first();
    test_skid();
    test_branch();
    test_flush();
    test_random();
    test_stall_sat();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
